project_4: RTL and testbench

- 4-bit signed (two's complement) calculator for the DE2-style board top level.
- Operands come from slide switches: A = SW[7:4], B = SW[3:0].
- The operation is selected by KEY[2:0].
- A, B and the result are shown as sign and magnitude on seven-segment displays; HEX0 shows "E" when the result overflows the 4-bit range.

---
 rtl/project_4.sv | 147 ++++++++++++++
 tb/tb_project_4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/project_4.sv
// 4-bit signed calculator: switches in, sign/magnitude seven-segment out.
// All HEX outputs share one register stage with synchronous blanking reset.
module project_4 (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] KEY,
  input  logic [7:0] SW,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX0
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NEG = 3'b010,
    OP_ABS = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // -8 negates to 4'b1000, which reads correctly as unsigned magnitude 8
  function automatic logic [3:0] f_mag(input logic [3:0] v);
    return v[3] ? (4'd0 - v) : v;
  endfunction

  function automatic logic [6:0] f_sign(input logic [3:0] v);
    return v[3] ? SEG_MINUS : SEG_BLANK;
  endfunction

  op_e        w_op;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_sum;
  logic [3:0] w_dif;
  logic [3:0] w_neg;
  logic       w_a_min;
  logic       w_sum_ovf;
  logic       w_dif_ovf;
  logic [3:0] w_r;
  logic       w_ovf;

  assign w_op      = op_e'(KEY);
  assign w_a       = SW[7:4];
  assign w_b       = SW[3:0];
  assign w_sum     = w_a + w_b;
  assign w_dif     = w_a - w_b;
  assign w_neg     = 4'd0 - w_a;
  assign w_a_min   = (w_a == 4'b1000);
  assign w_sum_ovf = (w_a[3] == w_b[3]) && (w_sum[3] != w_a[3]);
  assign w_dif_ovf = (w_a[3] != w_b[3]) && (w_dif[3] != w_a[3]);

  always_comb begin
    w_r   = 4'd0;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_r   = w_sum;
        w_ovf = w_sum_ovf;
      end
      OP_SUB: begin
        w_r   = w_dif;
        w_ovf = w_dif_ovf;
      end
      OP_NEG: begin
        w_r   = w_neg;
        w_ovf = w_a_min;
      end
      OP_ABS: begin
        w_r   = w_a[3] ? w_neg : w_a;
        w_ovf = w_a_min;
      end
      OP_AND: w_r = w_a & w_b;
      OP_OR:  w_r = w_a | w_b;
      OP_XOR: w_r = w_a ^ w_b;
      OP_NOT: w_r = ~w_a;
      default: begin
        w_r   = 4'd0;
        w_ovf = 1'b0;
      end
    endcase
  end

  logic [6:0] r_hex7;
  logic [6:0] r_hex6;
  logic [6:0] r_hex5;
  logic [6:0] r_hex4;
  logic [6:0] r_hex3;
  logic [6:0] r_hex2;
  logic [6:0] r_hex0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hex7 <= SEG_BLANK;
      r_hex6 <= SEG_BLANK;
      r_hex5 <= SEG_BLANK;
      r_hex4 <= SEG_BLANK;
      r_hex3 <= SEG_BLANK;
      r_hex2 <= SEG_BLANK;
      r_hex0 <= SEG_BLANK;
    end else begin
      r_hex7 <= f_sign(w_a);
      r_hex6 <= f_seg(f_mag(w_a));
      r_hex5 <= f_sign(w_b);
      r_hex4 <= f_seg(f_mag(w_b));
      r_hex3 <= f_sign(w_r);
      r_hex2 <= f_seg(f_mag(w_r));
      r_hex0 <= w_ovf ? SEG_E : SEG_BLANK;
    end
  end

  assign HEX7 = r_hex7;
  assign HEX6 = r_hex6;
  assign HEX5 = r_hex5;
  assign HEX4 = r_hex4;
  assign HEX3 = r_hex3;
  assign HEX2 = r_hex2;
  assign HEX0 = r_hex0;

endmodule

// File: tb/tb_project_4.sv
// Scoreboard bench for project_4: driver queues expected displays,
// monitor pops one entry per edge and checks outputs hold mid-cycle.
module tb_project_4;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GM = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GE = 7'b0000110;

  logic       clk;
  logic       reset;
  logic [2:0] KEY;
  logic [7:0] SW;
  logic [6:0] HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX0;

  project_4 dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .KEY      (KEY),
    .SW       (SW),
    .HEX7     (HEX7),
    .HEX6     (HEX6),
    .HEX5     (HEX5),
    .HEX4     (HEX4),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .HEX0     (HEX0)
  );

  typedef struct {
    string      name;
    logic [48:0] hex;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [48:0] pack(input logic [6:0] e7, e6, e5, e4,
                                       e3, e2, e0);
    return {e7, e6, e5, e4, e3, e2, e0};
  endfunction

  task automatic apply(input string nm, input logic rst,
                       input logic [7:0] sw, input logic [2:0] key,
                       input logic [6:0] e7, e6, e5, e4, e3, e2, e0);
    exp_t e;
    @(negedge clk);
    reset = rst;
    SW    = sw;
    KEY   = key;
    e.name = nm;
    e.hex  = pack(e7, e6, e5, e4, e3, e2, e0);
    q.push_back(e);
  endtask

  // first value is overwritten before the edge; only the second counts
  task automatic apply_mid(input string nm,
                           input logic [7:0] sw0, input logic [2:0] key0,
                           input logic [7:0] sw1, input logic [2:0] key1,
                           input logic [6:0] e7, e6, e5, e4, e3, e2, e0);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    SW    = sw0;
    KEY   = key0;
    #2;
    SW    = sw1;
    KEY   = key1;
    e.name = nm;
    e.hex  = pack(e7, e6, e5, e4, e3, e2, e0);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [48:0] cur;
    logic [48:0] got;
    bit          have_cur;
    have_cur = 0;
    cur      = '0;
    forever begin
      @(posedge clk);
      #1;
      got = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX0};
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (got !== e.hex) begin
          fails++;
          $display("FAIL %s: got %h required %h", e.name, got, e.hex);
        end
        cur      = e.hex;
        have_cur = 1;
      end
      #7;
      got = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX0};
      if (have_cur) begin
        tests++;
        if (got !== cur) begin
          fails++;
          $display("FAIL hold: got %h required %h", got, cur);
        end
      end
    end
  end

  initial begin : driver
    int n;
    reset = 1'b1;
    SW    = 8'h00;
    KEY   = 3'b000;
    apply("rst0", 1, 8'h13, 3'b000, GB, GB, GB, GB, GB, GB, GB);
    apply("rst1", 1, 8'h80, 3'b011, GB, GB, GB, GB, GB, GB, GB);
    apply("add1p3", 0, 8'h13, 3'b000, GB, G1, GB, G3, GB, G4, GB);
    apply("sub5m2", 0, 8'h52, 3'b001, GB, G5, GB, G2, GB, G3, GB);
    apply("sub2m5", 0, 8'h25, 3'b001, GB, G2, GB, G5, GM, G3, GB);
    apply("abs_m8", 0, 8'h80, 3'b011, GM, G8, GB, G0, GM, G8, GE);
    apply("add7p1", 0, 8'h71, 3'b000, GB, G7, GB, G1, GM, G8, GE);
    apply("subm8m7", 0, 8'h87, 3'b001, GM, G8, GB, G7, GB, G1, GE);
    apply("neg3", 0, 8'h30, 3'b010, GB, G3, GB, G0, GM, G3, GB);
    apply("neg_m8", 0, 8'h80, 3'b010, GM, G8, GB, G0, GM, G8, GE);
    apply("abs_m3", 0, 8'hD0, 3'b011, GM, G3, GB, G0, GB, G3, GB);
    apply("and", 0, 8'hC5, 3'b100, GM, G4, GB, G5, GB, G4, GB);
    apply("or", 0, 8'hC5, 3'b101, GM, G4, GB, G5, GM, G3, GB);
    apply("xor", 0, 8'hC5, 3'b110, GM, G4, GB, G5, GM, G7, GB);
    apply("not", 0, 8'hC5, 3'b111, GM, G4, GB, G5, GB, G3, GB);
    apply("addm1m1", 0, 8'hFF, 3'b000, GM, G1, GM, G1, GM, G2, GB);
    apply("addm8m8", 0, 8'h88, 3'b000, GM, G8, GM, G8, GB, G0, GE);
    apply("sub7mm1", 0, 8'h7F, 3'b001, GB, G7, GM, G1, GM, G8, GE);
    apply("add6m6", 0, 8'h6A, 3'b000, GB, G6, GM, G6, GB, G0, GB);
    apply_mid("midchg", 8'h13, 3'b000, 8'h52, 3'b001,
              GB, G5, GB, G2, GB, G3, GB);
    apply("rst_mid", 1, 8'h52, 3'b001, GB, GB, GB, GB, GB, GB, GB);
    apply("add6p6", 0, 8'h66, 3'b000, GB, G6, GB, G6, GM, G4, GE);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #9;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
